// File: rtl/btb_predictor_pkg.sv
// Shared types, default sizes and helpers for the BTB/BHT predictor.
package btb_predictor_pkg;

    localparam int DEF_ENTRIES     = 16;
    localparam int DEF_FETCH_WIDTH = 4;
    localparam int DEF_HIST_BITS   = 6;
    localparam int DEF_BHT_ENTRIES = 64;
    localparam int DEF_OPAQUE_BITS = 10;

    localparam logic [1:0] CTR_INIT   = 2'b01;  // weakly not-taken
    localparam logic [1:0] CTR_UNCOND = 2'b11;  // reported for jal/jalr hits

    // One BTB entry: full word-address tag, target and branch kind.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        logic        cond;
    } btb_entry_t;

    // Training event from execute, sized for the default configuration.
    typedef struct packed {
        logic [31:0]              pc;
        logic [31:0]              target;
        logic                     taken;
        logic                     cond;
        logic [DEF_HIST_BITS-1:0] history;
    } btb_update_t;

    typedef struct packed {
        logic [1:0]               counter;
        logic [DEF_HIST_BITS-1:0] history;
    } bht_resp_t;

    typedef struct packed {
        logic                                 hit;
        logic                                 taken;
        logic [DEF_FETCH_WIDTH-1:0]           mask;
        logic [$clog2(DEF_FETCH_WIDTH)-1:0]   bridx;
        logic [31:0]                          target;
        logic [DEF_OPAQUE_BITS-1:0]           entry;
        bht_resp_t                            bht;
    } btb_response_t;

    // 2-bit saturating counter step.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/btb_predictor_bht_table.sv
// bht_table: 2-bit direction counters, one combinational read, one saturating write.
module bht_table
    import btb_predictor_pkg::*;
#(
    parameter int BHT_ENTRIES = DEF_BHT_ENTRIES,
    parameter int IDX_BITS    = $clog2(BHT_ENTRIES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] i_rd_idx,
    output logic [1:0]          o_rd_ctr,
    input  logic                i_wr_en,
    input  logic [IDX_BITS-1:0] i_wr_idx,
    input  logic                i_wr_taken
);

    logic [1:0] r_ctr [BHT_ENTRIES];

    assign o_rd_ctr = r_ctr[i_rd_idx];

    // Counter storage: initialise to weakly not-taken, then one saturating step per update.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: a memory gets a reset only when its contents are visible straight after
            // reset; every counter here is, so the whole array is initialised.
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_ctr[i] <= CTR_INIT;
            end
        end else if (i_wr_en) begin
            // NOTE: <= keeps the read of r_ctr on the pre-edge value, so same-cycle lookups
            // in the parent see the old counter.
            r_ctr[i_wr_idx] <= ctr_next(r_ctr[i_wr_idx], i_wr_taken);
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// btb_predictor: fully associative BTB plus global-history BHT, registered 1-cycle lookup.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int ENTRIES     = DEF_ENTRIES,
    parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
    parameter int HIST_BITS   = DEF_HIST_BITS,
    parameter int BHT_ENTRIES = DEF_BHT_ENTRIES,
    parameter int OPAQUE_BITS = DEF_OPAQUE_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    input  logic [31:0]                    req_addr,
    input  logic                           flush,
    output logic                           resp_valid,
    output logic                           resp_hit,
    output logic                           resp_taken,
    output logic [FETCH_WIDTH-1:0]         resp_mask,
    output logic [$clog2(FETCH_WIDTH)-1:0] resp_bridx,
    output logic [31:0]                    resp_target,
    output logic [OPAQUE_BITS-1:0]         resp_entry,
    output logic [HIST_BITS-1:0]           resp_history,
    output logic [1:0]                     resp_counter,
    input  logic                           upd_valid,
    input  logic [31:0]                    upd_pc,
    input  logic [31:0]                    upd_target,
    input  logic                           upd_taken,
    input  logic                           upd_cond,
    input  logic [HIST_BITS-1:0]           upd_history
);

    localparam int OFF_BITS = $clog2(FETCH_WIDTH);
    localparam int IDX_BITS = $clog2(BHT_ENTRIES);
    localparam int ENT_BITS = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int BLK_BITS = 30 - OFF_BITS;

    btb_entry_t             r_btb [ENTRIES];
    logic [ENT_BITS-1:0]    r_rr_ptr;
    logic [HIST_BITS-1:0]   r_ghist;

    logic                   r_resp_valid, r_resp_hit, r_resp_taken;
    logic [FETCH_WIDTH-1:0] r_resp_mask;
    logic [OFF_BITS-1:0]    r_resp_bridx;
    logic [31:0]            r_resp_target;
    logic [OPAQUE_BITS-1:0] r_resp_entry;
    logic [HIST_BITS-1:0]   r_resp_history;
    logic [1:0]             r_resp_counter;

    logic [OFF_BITS-1:0]    w_req_off;
    logic [BLK_BITS-1:0]    w_req_blk;
    logic                   w_hit;
    logic [ENT_BITS-1:0]    w_win_idx;
    logic [OFF_BITS-1:0]    w_win_slot;
    logic                   w_win_cond;
    logic [31:0]            w_win_target;
    logic [IDX_BITS-1:0]    w_rd_idx;
    logic [1:0]             w_rd_ctr;
    logic                   w_taken;
    logic [1:0]             w_counter;
    logic [FETCH_WIDTH-1:0] w_mask;
    logic [OFF_BITS-1:0]    w_bridx;
    logic [31:0]            w_target;
    logic [OPAQUE_BITS-1:0] w_entry;

    logic                   w_upd_match;
    logic [ENT_BITS-1:0]    w_upd_match_idx;
    logic                   w_free;
    logic [ENT_BITS-1:0]    w_free_idx;
    logic [ENT_BITS-1:0]    w_alloc_idx;
    logic [IDX_BITS-1:0]    w_wr_idx;
    logic                   w_unused_bits;

    assign w_req_off     = req_addr[OFF_BITS+1:2];
    assign w_req_blk     = req_addr[31:OFF_BITS+2];
    assign w_unused_bits = ^{req_addr[1:0], upd_pc[1:0]};

    // CAM match and priority select: lowest slot at or after the request offset, lowest index on ties.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned (no latch).
        w_hit      = 1'b0;
        w_win_idx  = '0;
        w_win_slot = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_btb[i].valid && (r_btb[i].tag[29:OFF_BITS] == w_req_blk)
                && (r_btb[i].tag[OFF_BITS-1:0] >= w_req_off)
                && (!w_hit || (r_btb[i].tag[OFF_BITS-1:0] < w_win_slot))) begin
                w_hit      = 1'b1;
                w_win_idx  = ENT_BITS'(i);
                w_win_slot = r_btb[i].tag[OFF_BITS-1:0];
            end
        end
    end

    assign w_win_cond   = r_btb[w_win_idx].cond;
    assign w_win_target = r_btb[w_win_idx].target;
    assign w_rd_idx     = r_btb[w_win_idx].tag[IDX_BITS-1:0] ^ IDX_BITS'(r_ghist);

    // Response fields from the winner (or the fall-through prediction on a miss).
    always_comb begin
        w_taken   = w_hit && (!w_win_cond || w_rd_ctr[1]);
        w_counter = !w_hit ? 2'b00 : (w_win_cond ? w_rd_ctr : CTR_UNCOND);
        w_bridx   = w_hit ? w_win_slot : OFF_BITS'(FETCH_WIDTH - 1);
        w_target  = w_hit ? w_win_target
                          : ({w_req_blk, {(OFF_BITS + 2){1'b0}}} + 32'(FETCH_WIDTH * 4));
        w_entry   = w_hit ? OPAQUE_BITS'(w_win_idx) : '0;
        w_mask    = '0;
        for (int s = 0; s < FETCH_WIDTH; s++) begin
            w_mask[s] = (OFF_BITS'(s) >= w_req_off) && (!w_taken || (OFF_BITS'(s) <= w_win_slot));
        end
    end

    // Update-side search: existing entry for upd_pc, and lowest-index free slot.
    always_comb begin
        w_upd_match     = 1'b0;
        w_upd_match_idx = '0;
        w_free          = 1'b0;
        w_free_idx      = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_btb[i].valid && (r_btb[i].tag == upd_pc[31:2])) begin
                w_upd_match     = 1'b1;
                w_upd_match_idx = ENT_BITS'(i);
            end
            if (!r_btb[i].valid) begin
                w_free     = 1'b1;
                w_free_idx = ENT_BITS'(i);
            end
        end
    end

    assign w_alloc_idx = w_free ? w_free_idx : r_rr_ptr;
    assign w_wr_idx    = upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(upd_history);

    bht_table #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .IDX_BITS    (IDX_BITS)
    ) u_bht (
        .clk        (clk),
        .reset      (reset),
        .i_rd_idx   (w_rd_idx),
        .o_rd_ctr   (w_rd_ctr),
        .i_wr_en    (upd_valid && upd_cond),
        .i_wr_idx   (w_wr_idx),
        .i_wr_taken (upd_taken)
    );

    // BTB contents, round-robin pointer and global history; flush is applied first so an allocation survives it.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Tag/target/cond are meaningless while invalid, so only the valid bits are cleared.
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i].valid <= 1'b0;
            end
            r_rr_ptr <= '0;
            r_ghist  <= '0;
        end else begin
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    r_btb[i].valid <= 1'b0;
                end
            end
            if (upd_valid) begin
                if (upd_cond) begin
                    r_ghist <= {r_ghist[HIST_BITS-2:0], upd_taken};
                end
                if (w_upd_match) begin
                    if (upd_taken) begin
                        r_btb[w_upd_match_idx].target <= upd_target;
                        r_btb[w_upd_match_idx].cond   <= upd_cond;
                    end
                end else if (upd_taken) begin
                    r_btb[w_alloc_idx] <= '{valid: 1'b1, tag: upd_pc[31:2],
                                            target: upd_target, cond: upd_cond};
                    if (!w_free) begin
                        r_rr_ptr <= (r_rr_ptr == ENT_BITS'(ENTRIES - 1)) ? '0 : r_rr_ptr + 1'b1;
                    end
                end
            end
        end
    end

    // Registered response; fields hold when no request is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid   <= 1'b0;
            r_resp_hit     <= 1'b0;
            r_resp_taken   <= 1'b0;
            r_resp_mask    <= '0;
            r_resp_bridx   <= '0;
            r_resp_target  <= '0;
            r_resp_entry   <= '0;
            r_resp_history <= '0;
            r_resp_counter <= '0;
        end else begin
            r_resp_valid <= req_valid;
            if (req_valid) begin
                r_resp_hit     <= w_hit;
                r_resp_taken   <= w_taken;
                r_resp_mask    <= w_mask;
                r_resp_bridx   <= w_bridx;
                r_resp_target  <= w_target;
                r_resp_entry   <= w_entry;
                r_resp_history <= r_ghist;
                r_resp_counter <= w_counter;
            end
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_hit     = r_resp_hit;
    assign resp_taken   = r_resp_taken;
    assign resp_mask    = r_resp_mask;
    assign resp_bridx   = r_resp_bridx;
    assign resp_target  = r_resp_target;
    assign resp_entry   = r_resp_entry;
    assign resp_history = r_resp_history;
    assign resp_counter = r_resp_counter;

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed vector table, hand sequences, random vs. model.
module tb_btb_predictor;

    localparam int E   = 4;
    localparam int FW  = 4;
    localparam int HB  = 6;
    localparam int BHT = 64;
    localparam int OB  = 10;

    logic          clk = 1'b0;
    logic          reset, req_valid, flush, upd_valid, upd_taken, upd_cond;
    logic [31:0]   req_addr, upd_pc, upd_target;
    logic [HB-1:0] upd_history;
    logic          resp_valid, resp_hit, resp_taken;
    logic [FW-1:0] resp_mask;
    logic [1:0]    resp_bridx;
    logic [31:0]   resp_target;
    logic [OB-1:0] resp_entry;
    logic [HB-1:0] resp_history;
    logic [1:0]    resp_counter;

    always #5 clk = ~clk;

    btb_predictor #(
        .ENTRIES(E), .FETCH_WIDTH(FW), .HIST_BITS(HB), .BHT_ENTRIES(BHT), .OPAQUE_BITS(OB)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_taken(resp_taken),
        .resp_mask(resp_mask), .resp_bridx(resp_bridx), .resp_target(resp_target),
        .resp_entry(resp_entry), .resp_history(resp_history), .resp_counter(resp_counter),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_cond(upd_cond), .upd_history(upd_history)
    );

    typedef struct {
        logic          valid, hit, taken;
        logic [FW-1:0] mask;
        logic [1:0]    bridx;
        logic [31:0]   target;
        logic [OB-1:0] entry;
        logic [HB-1:0] history;
        logic [1:0]    counter;
    } resp_t;

    typedef struct {
        logic          rq;
        logic [31:0]   addr;
        logic          uv;
        logic [31:0]   pc, tgt;
        logic          tk, cd;
        logic [HB-1:0] hist;
        resp_t         exp;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: a list of remembered branches plus a counter array and history.
    bit          m_valid  [E];
    logic [31:0] m_pc     [E];
    logic [31:0] m_target [E];
    bit          m_cond   [E];
    int          m_bht    [BHT];
    int          m_ghist;
    int          m_rr;
    resp_t       exp_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_resp(input string tag, input resp_t e);
        check({tag, ".valid"},   32'(resp_valid),   32'(e.valid));
        check({tag, ".hit"},     32'(resp_hit),     32'(e.hit));
        check({tag, ".taken"},   32'(resp_taken),   32'(e.taken));
        check({tag, ".mask"},    32'(resp_mask),    32'(e.mask));
        check({tag, ".bridx"},   32'(resp_bridx),   32'(e.bridx));
        check({tag, ".target"},  resp_target,       e.target);
        check({tag, ".entry"},   32'(resp_entry),   32'(e.entry));
        check({tag, ".history"}, 32'(resp_history), 32'(e.history));
        check({tag, ".counter"}, 32'(resp_counter), 32'(e.counter));
    endtask

    task automatic model_reset();
        for (int i = 0; i < E; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < BHT; i++) m_bht[i] = 1;
        m_ghist = 0;
        m_rr    = 0;
        exp_r   = '{default: '0};
    endtask

    // One clock: drive inputs, predict from pre-edge model state, advance model, sample at +1.
    task automatic step(input bit rq, input logic [31:0] addr, input bit uv, input logic [31:0] pc,
                        input logic [31:0] tgt, input bit tk, input bit cd,
                        input logic [HB-1:0] hist, input bit fl);
        resp_t       nx;
        int          off, win, win_slot, last, ctr, match, free, slot, idx;
        logic [31:0] base;
        req_valid = rq; req_addr = addr; flush = fl;
        upd_valid = uv; upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_cond = cd; upd_history = hist;
        nx = exp_r;
        nx.valid = rq;
        if (rq) begin
            off  = int'((addr >> 2) % FW);
            base = addr & ~32'(FW * 4 - 1);
            win  = -1; win_slot = 0;
            for (int s = off; s < FW && win < 0; s++)
                for (int i = 0; i < E && win < 0; i++)
                    if (m_valid[i] && m_pc[i] == base + 32'(s * 4)) begin
                        win = i; win_slot = s;
                    end
            if (win < 0) begin
                nx.hit = 0; nx.taken = 0; nx.bridx = 2'(FW - 1); nx.target = base + 32'(FW * 4);
                nx.entry = '0; nx.counter = 2'd0; last = FW - 1;
            end else begin
                nx.hit = 1; nx.bridx = 2'(win_slot); nx.target = m_target[win]; nx.entry = OB'(win);
                if (m_cond[win]) begin
                    ctr = m_bht[int'(((m_pc[win] >> 2) ^ 32'(m_ghist)) & 32'(BHT - 1))];
                    nx.taken = (ctr >= 2); nx.counter = 2'(ctr);
                end else begin
                    nx.taken = 1; nx.counter = 2'd3;
                end
                last = nx.taken ? win_slot : FW - 1;
            end
            nx.mask = '0;
            for (int s = off; s <= last; s++) nx.mask[s] = 1'b1;
            nx.history = HB'(m_ghist);
        end
        @(posedge clk);
        match = -1; free = -1;
        if (uv) begin
            if (cd) begin
                idx = int'(((pc >> 2) ^ 32'(hist)) & 32'(BHT - 1));
                m_bht[idx] = tk ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                                : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
                m_ghist = ((m_ghist << 1) | int'(tk)) & ((1 << HB) - 1);
            end
            for (int i = 0; i < E; i++) if (m_valid[i] && m_pc[i] == pc && match < 0) match = i;
            for (int i = 0; i < E; i++) if (!m_valid[i] && free < 0) free = i;
        end
        if (fl) for (int i = 0; i < E; i++) m_valid[i] = 1'b0;
        if (uv && tk) begin
            if (match >= 0) begin
                m_target[match] = tgt; m_cond[match] = cd;
            end else begin
                slot = (free >= 0) ? free : m_rr;
                if (free < 0) m_rr = (m_rr + 1) % E;
                m_valid[slot] = 1'b1; m_pc[slot] = pc; m_target[slot] = tgt; m_cond[slot] = cd;
            end
        end
        exp_r = nx;
        #1;
    endtask

    task automatic req(input logic [31:0] addr);
        step(1'b1, addr, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk, input bit cd,
                       input logic [HB-1:0] hist);
        step(1'b0, 32'h0, 1'b1, pc, tgt, tk, cd, hist, 1'b0);
    endtask

    // Reset with every other input active: none of them may leave a trace.
    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b1; req_addr = 32'h100; flush = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h100; upd_target = 32'h900; upd_taken = 1'b1; upd_cond = 1'b1;
        upd_history = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; req_valid = 1'b0; flush = 1'b0; upd_valid = 1'b0;
        model_reset();
    endtask

    function automatic resp_t r(bit v, bit h, bit t, logic [3:0] m, logic [1:0] b, logic [31:0] tg,
                                logic [OB-1:0] en, logic [1:0] c, logic [HB-1:0] hs);
        resp_t x;
        x.valid = v; x.hit = h; x.taken = t; x.mask = m; x.bridx = b; x.target = tg;
        x.entry = en; x.counter = c; x.history = hs;
        return x;
    endfunction

    function automatic vec_t v(bit rq, logic [31:0] addr, bit uv, logic [31:0] pc, logic [31:0] tgt,
                               bit tk, bit cd, resp_t e);
        vec_t x;
        x.rq = rq; x.addr = addr; x.uv = uv; x.pc = pc; x.tgt = tgt; x.tk = tk; x.cd = cd;
        x.hist = '0; x.exp = e;
        return x;
    endfunction

    vec_t vecs [19];

    initial begin
        logic [31:0] a, p;
        logic [HB-1:0] h;
        bit rq, uv, tk, cd, fl;
        logic [HB-1:0] hseq [6];

        hseq[0] = 6'd3; hseq[1] = 6'd6; hseq[2] = 6'd12; hseq[3] = 6'd24; hseq[4] = 6'd48; hseq[5] = 6'd32;
        vecs[0]  = v(1, 32'h100, 0, 32'h0,   32'h0,   0, 0, r(1, 0, 0, 4'b1111, 2'd3, 32'h110, 0, 2'd0, 6'd0));
        vecs[1]  = v(0, 32'h0,   1, 32'h108, 32'h200, 1, 0, r(0, 0, 0, 4'b1111, 2'd3, 32'h110, 0, 2'd0, 6'd0));
        vecs[2]  = v(1, 32'h100, 0, 32'h0,   32'h0,   0, 0, r(1, 1, 1, 4'b0111, 2'd2, 32'h200, 0, 2'd3, 6'd0));
        vecs[3]  = v(1, 32'h10C, 0, 32'h0,   32'h0,   0, 0, r(1, 0, 0, 4'b1000, 2'd3, 32'h110, 0, 2'd0, 6'd0));
        vecs[4]  = v(0, 32'h0,   1, 32'h104, 32'h300, 1, 1, r(0, 0, 0, 4'b1000, 2'd3, 32'h110, 0, 2'd0, 6'd0));
        vecs[5]  = v(0, 32'h0,   1, 32'h104, 32'h300, 1, 1, r(0, 0, 0, 4'b1000, 2'd3, 32'h110, 0, 2'd0, 6'd0));
        vecs[6]  = v(1, 32'h100, 0, 32'h0,   32'h0,   0, 0, r(1, 1, 0, 4'b1111, 2'd1, 32'h300, 1, 2'd1, 6'd3));
        for (int k = 0; k < 6; k++)
            vecs[7 + k] = v(1, 32'h10C, 1, 32'h400, 32'h0, 0, 1,
                            r(1, 0, 0, 4'b1000, 2'd3, 32'h110, 0, 2'd0, hseq[k]));
        vecs[13] = v(1, 32'h100, 0, 32'h0,   32'h0,   0, 0, r(1, 1, 1, 4'b0011, 2'd1, 32'h300, 1, 2'd3, 6'd0));
        vecs[14] = v(1, 32'h100, 1, 32'h104, 32'h300, 0, 1, r(1, 1, 1, 4'b0011, 2'd1, 32'h300, 1, 2'd3, 6'd0));
        vecs[15] = v(1, 32'h100, 1, 32'h104, 32'h300, 0, 1, r(1, 1, 1, 4'b0011, 2'd1, 32'h300, 1, 2'd2, 6'd0));
        vecs[16] = v(1, 32'h100, 1, 32'h104, 32'h300, 0, 1, r(1, 1, 0, 4'b1111, 2'd1, 32'h300, 1, 2'd1, 6'd0));
        vecs[17] = v(1, 32'h100, 0, 32'h0,   32'h0,   0, 0, r(1, 1, 0, 4'b1111, 2'd1, 32'h300, 1, 2'd0, 6'd0));
        vecs[18] = v(1, 32'hFFFF_FFF8, 0, 32'h0, 32'h0, 0, 0, r(1, 0, 0, 4'b1100, 2'd3, 32'h0, 0, 2'd0, 6'd0));

        do_reset();
        check_resp("reset", r(0, 0, 0, 4'b0000, 2'd0, 32'h0, 0, 2'd0, 6'd0));

        // Directed table: fall-through, uncond hit, cond counters, history shifts, wrap.
        for (int k = 0; k < 19; k++) begin
            step(vecs[k].rq, vecs[k].addr, vecs[k].uv, vecs[k].pc, vecs[k].tgt,
                 vecs[k].tk, vecs[k].cd, vecs[k].hist, 1'b0);
            check_resp($sformatf("vec%0d", k), vecs[k].exp);
        end

        // Reset during activity, then same-cycle lookup/allocate (read-before-write).
        do_reset();
        check("rst2.valid", 32'(resp_valid), 32'h0);
        step(1'b1, 32'h100, 1'b1, 32'h100, 32'h500, 1'b1, 1'b0, '0, 1'b0);
        check("rbw.hit", 32'(resp_hit), 32'h0);
        check_resp("rbw", exp_r);
        req(32'h100);
        check("rbw2.hit", 32'(resp_hit), 32'h1);
        check("rbw2.entry", 32'(resp_entry), 32'h0);
        check("rbw2.mask", 32'(resp_mask), 32'h1);
        check("rbw2.target", resp_target, 32'h500);

        // Round-robin replacement with four entries.
        upd(32'h204, 32'h1204, 1'b1, 1'b0, '0);
        upd(32'h208, 32'h1208, 1'b1, 1'b0, '0);
        upd(32'h20C, 32'h120C, 1'b1, 1'b0, '0);
        upd(32'h300, 32'h1300, 1'b1, 1'b0, '0);
        upd(32'h310, 32'h1310, 1'b1, 1'b0, '0);
        req(32'h100);
        check("rr.first_gone", 32'(resp_hit), 32'h0);
        check_resp("rr.a", exp_r);
        req(32'h300);
        check("rr.fifth.entry", 32'(resp_entry), 32'h0);
        check("rr.fifth.target", resp_target, 32'h1300);
        req(32'h310);
        check("rr.sixth.entry", 32'(resp_entry), 32'h1);
        check("rr.sixth.target", resp_target, 32'h1310);
        req(32'h204);
        check("rr.blk.entry", 32'(resp_entry), 32'h2);
        check("rr.blk.bridx", 32'(resp_bridx), 32'h2);
        check_resp("rr.b", exp_r);

        // Flush: pending request still sees old contents; counters survive re-allocation.
        upd(32'h404, 32'h2404, 1'b1, 1'b1, '0);
        step(1'b1, 32'h300, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, 1'b1);
        check("flush.pending.hit", 32'(resp_hit), 32'h1);
        req(32'h300);
        check("flush.after.hit", 32'(resp_hit), 32'h0);
        upd(32'h404, 32'h2404, 1'b1, 1'b1, '0);
        for (int k = 0; k < 6; k++) upd(32'h800, 32'h0, 1'b0, 1'b1, '0);
        req(32'h400);
        check("flush.realloc.counter", 32'(resp_counter), 32'h3);
        check("flush.realloc.taken", 32'(resp_taken), 32'h1);
        check_resp("flush.realloc", exp_r);
        step(1'b0, 32'h0, 1'b1, 32'h600, 32'h1600, 1'b1, 1'b0, '0, 1'b1);
        req(32'h600);
        check("flush.alloc.hit", 32'(resp_hit), 32'h1);
        check("flush.alloc.entry", 32'(resp_entry), 32'h1);
        req(32'h400);
        check("flush.alloc.others", 32'(resp_hit), 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rq = ($urandom_range(0, 3) != 0);
            uv = ($urandom_range(0, 1) != 0);
            tk = ($urandom_range(0, 9) < 6);
            cd = ($urandom_range(0, 1) != 0);
            fl = ($urandom_range(0, 49) == 0);
            a  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFC0 + 32'($urandom_range(0, 15) * 4)
                                               : 32'h1000 + 32'($urandom_range(0, 63) * 4);
            p  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFC0 + 32'($urandom_range(0, 15) * 4)
                                               : 32'h1000 + 32'($urandom_range(0, 63) * 4);
            h  = ($urandom_range(0, 1) != 0) ? HB'(m_ghist) : HB'($urandom);
            step(rq, a, uv, p, $urandom, tk, cd, h, fl);
            check_resp($sformatf("rnd%0d", n), exp_r);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
